// File: rtl/uart_frame_parser_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_parser_if
// Brief    : Byte-in / payload-out bundle between the UART receiver side,
//            the frame parser and the downstream payload consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_frame_parser_if;
    logic [7:0] data;
    logic       rx_recieved;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic       busy;

    modport master (
        output data, rx_recieved, out_ready,
        input  out_data, out_valid, out_last, frame_ok, frame_err, err_code, busy
    );

    modport slave (
        input  data, rx_recieved, out_ready,
        output out_data, out_valid, out_last, frame_ok, frame_err, err_code, busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_frame_parser.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_parser
// Brief    : Parses SOF/LEN/payload/CSUM frames from a UART byte strobe and
//            replays a checksum-verified payload over a valid/ready stream.
// Revision : 1.0 - initial release
// ============================================================================
module uart_frame_parser #(
    parameter logic [7:0] SOF     = 8'hA5,
    parameter int         MAX_LEN = 16,
    parameter int         TIMEOUT = 21700
) (
    input  logic               clk,
    input  logic               rst,
    uart_frame_parser_if.slave bus
);

    localparam int IDX_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int DEPTH  = 1 << IDX_W;
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    localparam logic [1:0] ERR_TIMEOUT = 2'b00;
    localparam logic [1:0] ERR_LEN     = 2'b01;
    localparam logic [1:0] ERR_CSUM    = 2'b10;
    localparam logic [1:0] ERR_OVERRUN = 2'b11;

    typedef enum logic [2:0] {
        WAIT_SOF    = 3'd0,
        GET_LEN     = 3'd1,
        GET_PAYLOAD = 3'd2,
        GET_CSUM    = 3'd3,
        DRAIN       = 3'd4
    } state_t;

    state_t            state_q;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  rd_idx_q;
    logic [IDX_W-1:0]  rd_idx_d;
    logic [IDX_W-1:0]  len_m1_q;
    logic [7:0]        csum_q;
    logic [IDLE_W-1:0] idle_q;
    logic [7:0]        buf_q [DEPTH];

    logic [7:0]        out_data_q;
    logic              out_valid_q;
    logic              out_last_q;
    logic              frame_ok_q;
    logic              frame_err_q;
    logic [1:0]        err_code_q;

    logic              w_collecting;
    logic              w_timeout;
    logic              w_buf_we;

    assign w_collecting = (state_q == GET_LEN) || (state_q == GET_PAYLOAD) ||
                          (state_q == GET_CSUM);
    // A strobe landing on the expiry cycle takes priority over the abort
    assign w_timeout    = w_collecting && !bus.rx_recieved && (idle_q == IDLE_LAST);
    assign w_buf_we     = !rst && (state_q == GET_PAYLOAD) && bus.rx_recieved;
    assign rd_idx_d     = rd_idx_q + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (w_buf_we) begin
            buf_q[idx_q] <= bus.data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WAIT_SOF;
            idx_q       <= '0;
            rd_idx_q    <= '0;
            len_m1_q    <= '0;
            csum_q      <= '0;
            idle_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= 2'b00;
        end else begin
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= 2'b00;

            if (w_collecting && !bus.rx_recieved) begin
                idle_q <= idle_q + IDLE_W'(1);
            end else begin
                idle_q <= '0;
            end

            if (w_timeout) begin
                frame_err_q <= 1'b1;
                err_code_q  <= ERR_TIMEOUT;
                state_q     <= WAIT_SOF;
            end else begin
                case (state_q)
                    WAIT_SOF: begin
                        if (bus.rx_recieved && (bus.data == SOF)) begin
                            state_q <= GET_LEN;
                        end
                    end
                    GET_LEN: begin
                        if (bus.rx_recieved) begin
                            if ((bus.data == 8'd0) || (bus.data > 8'(MAX_LEN))) begin
                                frame_err_q <= 1'b1;
                                err_code_q  <= ERR_LEN;
                                state_q     <= WAIT_SOF;
                            end else begin
                                len_m1_q <= IDX_W'(bus.data - 8'd1);
                                csum_q   <= bus.data;
                                idx_q    <= '0;
                                state_q  <= GET_PAYLOAD;
                            end
                        end
                    end
                    GET_PAYLOAD: begin
                        if (bus.rx_recieved) begin
                            csum_q <= csum_q ^ bus.data;
                            if (idx_q == len_m1_q) begin
                                state_q <= GET_CSUM;
                            end else begin
                                idx_q <= idx_q + IDX_W'(1);
                            end
                        end
                    end
                    GET_CSUM: begin
                        if (bus.rx_recieved) begin
                            if (bus.data == csum_q) begin
                                frame_ok_q  <= 1'b1;
                                rd_idx_q    <= '0;
                                out_valid_q <= 1'b1;
                                out_data_q  <= buf_q[0];
                                out_last_q  <= (len_m1_q == '0);
                                state_q     <= DRAIN;
                            end else begin
                                frame_err_q <= 1'b1;
                                err_code_q  <= ERR_CSUM;
                                state_q     <= WAIT_SOF;
                            end
                        end
                    end
                    DRAIN: begin
                        // Incoming bytes cannot be buffered while replaying
                        if (bus.rx_recieved) begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= ERR_OVERRUN;
                        end
                        if (bus.out_ready) begin
                            if (out_last_q) begin
                                out_valid_q <= 1'b0;
                                out_data_q  <= '0;
                                out_last_q  <= 1'b0;
                                state_q     <= WAIT_SOF;
                            end else begin
                                rd_idx_q   <= rd_idx_d;
                                out_data_q <= buf_q[rd_idx_d];
                                out_last_q <= (rd_idx_d == len_m1_q);
                            end
                        end
                    end
                    default: begin
                        state_q <= WAIT_SOF;
                    end
                endcase
            end
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.frame_ok  = frame_ok_q;
    assign bus.frame_err = frame_err_q;
    assign bus.err_code  = err_code_q;
    assign bus.busy      = (state_q != WAIT_SOF);

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_frame_parser
// Brief    : Directed self-checking bench for uart_frame_parser.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_frame_parser;

    localparam int TMO = 50;

    logic clk;
    logic rst;
    uart_frame_parser_if bus ();

    uart_frame_parser #(
        .SOF     (8'hA5),
        .MAX_LEN (16),
        .TIMEOUT (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled on the falling edge
    int         ok_cnt, err_cnt, both_cnt, valid_cnt, ok_cyc, vrise_cyc;
    logic [1:0] last_err;
    logic       prev_valid;
    logic [7:0] out_q [$];
    logic       lst_q [$];
    int         cyc_q [$];
    logic [7:0] tx_q  [$];
    logic [7:0] exp_q [$];

    initial prev_valid = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.frame_ok) begin
                ok_cnt++;
                ok_cyc = cyc;
            end
            if (bus.frame_err) begin
                err_cnt++;
                last_err = bus.err_code;
            end
            if (bus.frame_ok && bus.frame_err) both_cnt++;
            if (bus.out_valid) valid_cnt++;
            if (bus.out_valid && !prev_valid) vrise_cyc = cyc;
            if (bus.out_valid && bus.out_ready) begin
                out_q.push_back(bus.out_data);
                lst_q.push_back(bus.out_last);
                cyc_q.push_back(cyc);
            end
        end
        prev_valid = bus.out_valid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        ok_cnt    = 0;
        err_cnt   = 0;
        both_cnt  = 0;
        valid_cnt = 0;
        ok_cyc    = -1;
        vrise_cyc = -2;
        last_err  = 2'b00;
        out_q.delete();
        lst_q.delete();
        cyc_q.delete();
    endtask

    // Strobe is sampled on the next rising edge; returns just after it
    task automatic send_byte(input logic [7:0] b);
        bus.data        = b;
        bus.rx_recieved = 1'b1;
        tick(1);
        bus.rx_recieved = 1'b0;
    endtask

    task automatic send_all();
        foreach (tx_q[i]) send_byte(tx_q[i]);
    endtask

    task automatic check_payload(input string tag, input logic gapless);
        check({tag, "_count"}, out_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            check($sformatf("%s_data%0d", tag, i), out_q[i], exp_q[i]);
            check($sformatf("%s_last%0d", tag, i), lst_q[i], (i == exp_q.size() - 1));
            if (gapless && i > 0)
                check($sformatf("%s_gap%0d", tag, i), cyc_q[i] - cyc_q[i-1], 1);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_out_data"},  bus.out_data,  0);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_out_last"},  bus.out_last,  0);
        check({tag, "_frame_ok"},  bus.frame_ok,  0);
        check({tag, "_frame_err"}, bus.frame_err, 0);
        check({tag, "_err_code"},  bus.err_code,  0);
        check({tag, "_busy"},      bus.busy,      0);
    endtask

    int   fire_at;
    logic [1:0] fire_code;
    int   unstable;

    initial begin
        rst             = 1'b1;
        bus.data        = 8'h00;
        bus.rx_recieved = 1'b0;
        bus.out_ready   = 1'b1;
        clear_mon();
        tick(3);
        check_idle_outputs("reset");
        rst = 1'b0;
        tick(2);

        // Basic frame with leading junk byte
        clear_mon();
        tx_q  = '{8'h3C, 8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        exp_q = '{8'h11, 8'h22, 8'h33};
        send_all();
        tick(8);
        check("basic_ok_cnt", ok_cnt, 1);
        check("basic_err_cnt", err_cnt, 0);
        check("basic_valid_with_ok", vrise_cyc, ok_cyc);
        check_payload("basic", 1'b1);
        check("basic_busy_after", bus.busy, 0);

        // Checksum mismatch
        clear_mon();
        tx_q = '{8'hA5, 8'h02, 8'hAA, 8'h55, 8'h00};
        send_all();
        check("csum_err_now", bus.frame_err, 1);
        check("csum_code", bus.err_code, 2'b10);
        tick(5);
        check("csum_err_cnt", err_cnt, 1);
        check("csum_no_ok", ok_cnt, 0);
        check("csum_no_valid", valid_cnt, 0);

        // Length errors: zero and MAX_LEN+1
        clear_mon();
        send_byte(8'hA5);
        check("len0_busy_before", bus.busy, 1);
        send_byte(8'h00);
        check("len0_err", bus.frame_err, 1);
        check("len0_code", bus.err_code, 2'b01);
        check("len0_busy_drop", bus.busy, 0);
        tick(2);
        send_byte(8'hA5);
        send_byte(8'h11);
        check("len17_err", bus.frame_err, 1);
        check("len17_code", bus.err_code, 2'b01);
        check("len17_busy_drop", bus.busy, 0);
        tick(2);
        check("len_err_cnt", err_cnt, 2);

        // Boundary lengths: MAX_LEN and 1
        clear_mon();
        tx_q = '{8'hA5, 8'h10};
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            tx_q.push_back(8'(i));
            exp_q.push_back(8'(i));
        end
        tx_q.push_back(8'h10);
        send_all();
        tick(20);
        check("len16_ok_cnt", ok_cnt, 1);
        check_payload("len16", 1'b1);

        clear_mon();
        tx_q  = '{8'hA5, 8'h01, 8'h5A, 8'h5B};
        exp_q = '{8'h5A};
        send_all();
        tick(4);
        check_payload("len1", 1'b1);

        // SOF value inside the payload is plain data
        clear_mon();
        tx_q  = '{8'hA5, 8'h02, 8'hA5, 8'hA5, 8'h02};
        exp_q = '{8'hA5, 8'hA5};
        send_all();
        tick(5);
        check("sofdata_ok_cnt", ok_cnt, 1);
        check_payload("sofdata", 1'b1);

        // Idle timeout, then recovery
        clear_mon();
        tx_q = '{8'hA5, 8'h02, 8'hAA};
        send_all();
        fire_at   = 0;
        fire_code = 2'b11;
        for (int k = 1; k <= TMO + 5; k++) begin
            tick(1);
            if (bus.frame_err && fire_at == 0) begin
                fire_at   = k;
                fire_code = bus.err_code;
            end
        end
        check("tmo_cycles", fire_at, TMO);
        check("tmo_code", fire_code, 2'b00);
        check("tmo_busy", bus.busy, 0);
        clear_mon();
        tx_q  = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h01};
        exp_q = '{8'h01, 8'h02};
        send_all();
        tick(5);
        check("tmo_recover_ok", ok_cnt, 1);
        check_payload("tmo_recover", 1'b1);

        // Strobe on the expiry cycle wins over the timeout
        clear_mon();
        send_byte(8'hA5);
        tick(TMO - 1);
        tx_q  = '{8'h01, 8'h44, 8'h45};
        exp_q = '{8'h44};
        send_all();
        tick(4);
        check("race_err_cnt", err_cnt, 0);
        check("race_ok_cnt", ok_cnt, 1);
        check_payload("race", 1'b1);

        // Backpressure with overrun strobe
        clear_mon();
        bus.out_ready = 1'b0;
        tx_q  = '{8'hA5, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40, 8'h44};
        exp_q = '{8'h10, 8'h20, 8'h30, 8'h40};
        send_all();
        check("bp_ok_now", bus.frame_ok, 1);
        check("bp_valid_now", bus.out_valid, 1);
        unstable = 0;
        for (int i = 0; i < 100; i++) begin
            if (i == 50) begin
                send_byte(8'h77);
                check("ovr_err", bus.frame_err, 1);
                check("ovr_code", bus.err_code, 2'b11);
            end else begin
                tick(1);
            end
            if (bus.out_data !== 8'h10 || bus.out_last !== 1'b0 || bus.out_valid !== 1'b1)
                unstable++;
        end
        check("bp_unstable", unstable, 0);
        check("bp_err_cnt", err_cnt, 1);
        bus.out_ready = 1'b1;
        tick(8);
        check_payload("bp", 1'b1);
        check("bp_busy_after", bus.busy, 0);
        check("ok_err_exclusive", both_cnt, 0);

        // Reset mid-payload
        clear_mon();
        tx_q = '{8'hA5, 8'h05, 8'h01, 8'h02};
        send_all();
        check("rst_busy_before", bus.busy, 1);
        rst = 1'b1;
        tick(1);
        check_idle_outputs("midrst");
        rst = 1'b0;
        tick(3);
        check("midrst_no_err", err_cnt, 0);
        tx_q  = '{8'hA5, 8'h03, 8'h0A, 8'h0B, 8'h0C, 8'h0E};
        exp_q = '{8'h0A, 8'h0B, 8'h0C};
        send_all();
        tick(6);
        check("midrst_ok_cnt", ok_cnt, 1);
        check("midrst_err_cnt", err_cnt, 0);
        check_payload("midrst", 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_frame_parser.md
UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 SHALL have parameter SOF, default 8'hA5, meaning the start-of-frame byte value.
REQ-002 SHALL have parameter MAX_LEN, default 16 (legal range 1..64), meaning the maximum payload length in bytes.
REQ-003 SHALL have parameter TIMEOUT, default 21700 (5 byte times at 434 clk/bit), meaning the number of idle clocks that aborts a frame.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: the reset, which is synchronous and active-high.
REQ-006 SHALL have port data, input, 8 bits: the received byte from the UART receiver.
REQ-007 SHALL have port rx_recieved, input, 1 bit: a one-cycle strobe marking data valid.
REQ-008 SHALL have port out_data, output, 8 bits: the payload byte stream.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the downstream block accepts out_data.
REQ-011 SHALL have port out_last, output, 1 bit: the current byte is the final payload byte.
REQ-012 SHALL have port frame_ok, output, 1 bit: a one-cycle pulse marking a good frame.
REQ-013 SHALL have port frame_err, output, 1 bit: a one-cycle pulse marking an error.
REQ-014 SHALL have port err_code, output, 2 bits: the error cause, valid while frame_err is high.
REQ-015 SHALL have port busy, output, 1 bit: high whenever the state is not WAIT_SOF.

Function
REQ-016 Frame format SHALL be SOF, LEN, LEN payload bytes, CSUM, where CSUM = XOR of LEN and all payload bytes.
REQ-017 The state machine SHALL have exactly the states WAIT_SOF, GET_LEN, GET_PAYLOAD, GET_CSUM and DRAIN.
REQ-018 WAIT_SOF: a strobe with data==SOF SHALL move the FSM to GET_LEN; any other byte SHALL be discarded silently.
REQ-019 GET_LEN: on a strobe, LEN==0 or LEN>MAX_LEN SHALL raise frame_err with err_code=2'b01 and return to WAIT_SOF.
REQ-020 GET_LEN: a legal LEN SHALL be stored, csum SHALL be set to LEN, idx SHALL be cleared, and the FSM SHALL move to GET_PAYLOAD.
REQ-021 GET_PAYLOAD: each strobe SHALL write buf[idx], update csum^=data and increment idx; after the LEN-th byte the FSM SHALL move to GET_CSUM.
REQ-022 GET_CSUM: a strobe with data==csum SHALL pulse frame_ok, set rd_idx=0 and move to DRAIN.
REQ-023 GET_CSUM: a strobe with data!=csum SHALL raise frame_err with err_code=2'b10 and return to WAIT_SOF; no out_valid SHALL assert.
REQ-024 DRAIN: out_valid SHALL be 1, out_data SHALL equal buf[rd_idx], and out_last SHALL be (rd_idx==LEN-1).
REQ-025 DRAIN: out_valid&&out_ready SHALL advance rd_idx; a handshake on the last byte SHALL return the FSM to WAIT_SOF.
REQ-026 While out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable.
REQ-027 When out_valid=0, out_data and out_last SHALL be 0.
REQ-028 With out_ready held high, one byte SHALL be delivered per clock.
REQ-029 A strobe during DRAIN SHALL be dropped, SHALL raise frame_err with err_code=2'b11 (overrun), and SHALL leave the drain unaffected.
REQ-030 In GET_LEN, GET_PAYLOAD and GET_CSUM, an idle counter SHALL clear on each strobe and increment otherwise.
REQ-031 After TIMEOUT consecutive cycles without a strobe, the block SHALL raise frame_err with err_code=2'b00 and return to WAIT_SOF.
REQ-032 A strobe in the same cycle the timeout would fire SHALL win: the byte is processed and no error is raised.
REQ-033 frame_ok and frame_err SHALL be registered and assert the cycle after the causing strobe or timeout, for exactly one cycle.
REQ-034 out_valid SHALL first assert in the same cycle as frame_ok.
REQ-035 frame_ok and frame_err SHALL never assert together.
REQ-036 An SOF byte received mid-frame SHALL be treated as ordinary data, with no resync.

Reset
REQ-037 rst=1 SHALL, at the next clk edge, force state=WAIT_SOF and clear idx, rd_idx, csum and the idle counter.
REQ-038 During reset, out_data, out_valid, out_last, frame_ok, frame_err, err_code and busy SHALL all be 0.
REQ-039 Reset mid-frame or mid-drain SHALL discard the frame without raising any error pulse; buffer contents need not be cleared.

Verification
REQ-040 Stimulus 3C A5 03 11 22 33 03 with out_ready=1 SHALL produce frame_ok once, then out_data 11,22,33 on consecutive cycles, with out_last on 33.
REQ-041 Stimulus A5 02 AA 55 00 (expected CSUM FD) SHALL produce frame_err with err_code=10, and out_valid SHALL stay 0.
REQ-042 Stimuli A5 00 and A5 11 (LEN 17) SHALL each produce frame_err with err_code=01, and busy SHALL drop on the following cycle.
REQ-043 Stimulus A5 02 AA followed by silence SHALL produce frame_err with err_code=00 after exactly TIMEOUT idle cycles; a subsequent valid frame SHALL parse correctly.
REQ-044 A valid 4-byte frame with out_ready=0 for 100 cycles SHALL keep out_data stable; a 0x77 strobe in that window SHALL produce err_code=11 with the payload unchanged.
REQ-045 rst pulsed after 2 of 5 payload bytes SHALL zero all outputs; the next valid frame SHALL deliver its correct payload.
